// File: rtl/mmio_responder_if.sv
// rtl/mmio_responder_if.sv - memory-port and producer/consumer bundle for mmio_responder
// Purpose: groups the CPU memory request/response signals, the input-FIFO
//   producer stream and the output-register consumer stream.
// Ports (signals):
//   MemAddr, MemWriteData, MemRead, MemWrite   request from the CPU side
//   Sel, MemReady, MemReadData                 response to the CPU side
//   InData, InValid / InReady                  producer stream into the FIFO
//   OutData, OutValid / OutAck                 consumer stream from DATA_OUT
// Modports: master = CPU/producer/consumer side, slave = responder.
interface mmio_responder_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       MemAddr;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemRead;
  logic              MemWrite;
  logic              Sel;
  logic              MemReady;
  logic [DATA_W-1:0] MemReadData;
  logic [DATA_W-1:0] InData;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] OutData;
  logic              OutValid;
  logic              OutAck;

  modport master (
    output MemAddr, MemWriteData, MemRead, MemWrite, InData, InValid, OutAck,
    input  Sel, MemReady, MemReadData, InReady, OutData, OutValid
  );

  modport slave (
    input  MemAddr, MemWriteData, MemRead, MemWrite, InData, InValid, OutAck,
    output Sel, MemReady, MemReadData, InReady, OutData, OutValid
  );
endinterface

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - 4-word memory-mapped I/O responder with input FIFO and output register
// Purpose: answers loads/stores in the window BASE..BASE+3 with a one-cycle
//   MemReady strobe after WAIT_CYCLES wait cycles.
//   offset 0 DATA_IN  (R: pop FIFO head, 0 when empty)
//   offset 1 DATA_OUT (W: load output register, R: output register)
//   offset 2 STATUS   (R: {ovf, OutValid, inFull, inNotEmpty}, clears ovf)
//   offset 3 reserved
// Ports:
//   CLK    in  clock, rising edge
//   Reset  in  asynchronous active-high reset
//   bus    slave modport of mmio_responder_if (memory port + streams)
module mmio_responder #(
  parameter int          DATA_W      = 16,
  parameter logic [15:0] BASE        = 16'hFF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          WAIT_CYCLES = 1
) (
  input logic              CLK,
  input logic              Reset,
  mmio_responder_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t            state;
  logic [WW-1:0]     wcnt;
  logic [1:0]        off;
  logic              op_wr;
  logic              op_rd;
  logic [DATA_W-1:0] wdata;
  logic              mem_ready;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              ovf;

  logic              in_full;
  logic              not_empty;
  logic              push;
  logic              commit;
  logic              pop;
  logic              store_out;
  logic              status_rd;
  logic [DATA_W-1:0] rdata;

  assign bus.Sel      = (bus.MemAddr[15:2] == BASE[15:2]);
  assign in_full      = (count == CW'(FIFO_DEPTH));
  assign not_empty    = (count != '0);
  assign bus.InReady  = !in_full;
  assign push         = bus.InValid && !in_full;

  // All side effects happen on the single RESP cycle, so a request held high
  // in HOLD can never repeat them.
  assign commit       = (state == RESP);
  assign pop          = commit && op_rd && (off == 2'd0) && not_empty;
  assign store_out    = commit && op_wr && (off == 2'd1);
  assign status_rd    = commit && op_rd && (off == 2'd2);

  // Read data comes from the live FIFO/register state during RESP, so a word
  // pushed at the end of RESP is not seen by that read.
  always_comb begin
    rdata = '0;
    if (commit && op_rd) begin
      case (off)
        2'd0:    rdata = not_empty ? fifo_mem[rd_ptr] : '0;
        2'd1:    rdata = out_data;
        2'd2:    rdata = DATA_W'({ovf, out_valid, in_full, not_empty});
        default: rdata = '0;
      endcase
    end
  end

  assign bus.MemReadData = rdata;
  assign bus.MemReady    = mem_ready;
  assign bus.OutData     = out_data;
  assign bus.OutValid    = out_valid;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      off       <= 2'd0;
      op_wr     <= 1'b0;
      op_rd     <= 1'b0;
      wdata     <= '0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if ((bus.MemRead || bus.MemWrite) && bus.Sel) begin
            off   <= bus.MemAddr[1:0];
            op_wr <= bus.MemWrite;
            // A simultaneous read+write is a plain store.
            op_rd <= bus.MemRead && !bus.MemWrite;
            wdata <= bus.MemWriteData;
            wcnt  <= '0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
            end else begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wcnt == WW'(WAIT_CYCLES - 1)) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          mem_ready <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (!bus.MemRead && !bus.MemWrite) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= bus.InData;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // OutAck in the commit cycle frees the register for the incoming store,
  // so the store is accepted and OutValid stays set.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (store_out) begin
        if (out_valid && !bus.OutAck) begin
          ovf <= 1'b1;
        end else begin
          out_data  <= wdata;
          out_valid <= 1'b1;
        end
      end else if (bus.OutAck) begin
        out_valid <= 1'b0;
      end
      if (status_rd) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - scoreboard bench for mmio_responder with a queue-based reference model
module tb_mmio_responder;
  localparam int W = 1;

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  mmio_responder_if #(.DATA_W(16)) bus ();

  mmio_responder #(
    .DATA_W(16), .BASE(16'hFF00), .FIFO_DEPTH(4), .WAIT_CYCLES(W)
  ) dut (
    .CLK(CLK), .Reset(Reset), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] fq[$];
  bit          m_ov;
  bit          m_ovf;
  logic [15:0] m_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!Reset) begin
      if (bus.MemReady === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready: got MemReady=1 at cycle %0d expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("read_data", bus.MemReadData, mon_e.data);
          chk("latency", cyc, mon_e.due);
        end
      end else begin
        chk("idle_rdata", bus.MemReadData, 0);
      end
    end
  end

  task automatic model_op(input logic [1:0] off, input bit rd, input bit wr,
                          input logic [15:0] wd, output logic [15:0] d);
    d = 16'h0;
    if (wr) begin
      if (off == 2'd1) begin
        if (m_ov) m_ovf = 1'b1;
        else begin
          m_od = wd;
          m_ov = 1'b1;
        end
      end
    end else if (rd) begin
      case (off)
        2'd0: if (fq.size() > 0) d = fq.pop_front();
        2'd1: d = m_od;
        2'd2: begin
          d = {12'h0, m_ovf, m_ov, fq.size() == 4, fq.size() != 0};
          m_ovf = 1'b0;
        end
        default: d = 16'h0;
      endcase
    end
  endtask

  task automatic check_state();
    chk("out_data", bus.OutData, m_od);
    chk("out_valid", bus.OutValid, m_ov);
    chk("in_ready", bus.InReady, fq.size() < 4);
  endtask

  task automatic push_word(input logic [15:0] d);
    chk("in_ready_pre", bus.InReady, fq.size() < 4);
    bus.InValid = 1'b1;
    bus.InData  = d;
    @(posedge CLK); #1;
    bus.InValid = 1'b0;
    if (fq.size() < 4) fq.push_back(d);
  endtask

  task automatic do_ack();
    bus.OutAck = 1'b1;
    @(posedge CLK); #1;
    bus.OutAck = 1'b0;
    m_ov = 1'b0;
  endtask

  // Called at posedge+1. resp_push drives a producer word during the RESP
  // cycle; when the FIFO is full it is held one more edge until the pop frees room.
  task automatic do_access(input logic [15:0] addr, input bit rd, input bit wr,
                           input logic [15:0] wd, input int hold,
                           input bit resp_push, input logic [15:0] pd);
    bit          sel;
    bit          full_pop;
    bit          got;
    logic [15:0] d;
    exp_t        e;
    sel      = (addr[15:2] == 14'h3FC0);
    full_pop = (fq.size() == 4) && rd && !wr && (addr[1:0] == 2'd0);
    bus.MemAddr      = addr;
    bus.MemWriteData = wd;
    bus.MemRead      = rd;
    bus.MemWrite     = wr;
    #1;
    chk("sel", bus.Sel, sel);
    if (sel) begin
      model_op(addr[1:0], rd, wr, wd, d);
      e.data = d;
      e.due  = cyc + 1 + W;
      sb.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge CLK);
        if (bus.MemReady === 1'b1) got = 1'b1;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got no MemReady for addr %h expected one", addr);
        void'(sb.pop_back());
        @(posedge CLK); #1;
      end else if (resp_push) begin
        bus.InValid = 1'b1;
        bus.InData  = pd;
        @(posedge CLK);
        if (full_pop) @(posedge CLK);
        #1;
        bus.InValid = 1'b0;
        fq.push_back(pd);
      end else begin
        @(posedge CLK); #1;
      end
      repeat (hold) begin @(posedge CLK); #1; end
    end else begin
      repeat (hold + 3) begin @(posedge CLK); #1; end
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    @(posedge CLK); #1;
    check_state();
  endtask

  logic [15:0] ra;
  bit          rr;
  bit          rw;
  bit          rp;
  int          k;

  initial begin
    bus.MemAddr = 16'h0; bus.MemWriteData = 16'h0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    bus.InData = 16'h0; bus.InValid = 1'b0; bus.OutAck = 1'b0;
    m_ov = 1'b0; m_ovf = 1'b0; m_od = 16'h0;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", bus.MemReady, 0);
    chk("rst_rdata", bus.MemReadData, 0);
    check_state();
    Reset = 1'b0;
    @(posedge CLK); #1;

    // Store, latency and acknowledge
    do_access(16'hFF01, 1'b0, 1'b1, 16'h1234, 0, 1'b0, 16'h0);
    do_access(16'hFF01, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_ack();
    check_state();

    // Fill FIFO, fifth word held off, drain, empty read, status
    for (int i = 1; i <= 5; i++) push_word(16'hA000 + 16'(i));
    check_state();
    for (int i = 0; i < 5; i++) do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_access(16'hFF02, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);

    // Overflow and sticky ovf cleared by STATUS read
    do_access(16'hFF01, 1'b0, 1'b1, 16'h0001, 0, 1'b0, 16'h0);
    do_access(16'hFF01, 1'b0, 1'b1, 16'h0002, 0, 1'b0, 16'h0);
    do_access(16'hFF02, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_access(16'hFF02, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_ack();

    // Held request pops once; out-of-window access ignored; read+write is a store
    push_word(16'hB001);
    push_word(16'hB002);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 5, 1'b0, 16'h0);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_access(16'h1000, 1'b1, 1'b0, 16'h0, 2, 1'b0, 16'h0);
    do_access(16'hFF01, 1'b1, 1'b1, 16'h7777, 0, 1'b0, 16'h0);
    do_ack();

    // Push during RESP: full FIFO, partially full, and empty
    for (int i = 1; i <= 4; i++) push_word(16'hC000 + 16'(i));
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b1, 16'hC005);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b1, 16'hC006);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b1, 16'hC007);
    for (int i = 0; i < 4; i++) do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b1, 16'hD001);
    do_access(16'hFF00, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);

    // Reset asserted while a load sits in WAIT
    do_access(16'hFF01, 1'b0, 1'b1, 16'h5555, 0, 1'b0, 16'h0);
    for (int i = 1; i <= 4; i++) push_word(16'hE000 + 16'(i));
    bus.MemAddr = 16'hFF00;
    bus.MemRead = 1'b1;
    @(posedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_wait_ready", bus.MemReady, 0);
    chk("rst_wait_outvalid", bus.OutValid, 0);
    chk("rst_wait_inready", bus.InReady, 1);
    bus.MemRead = 1'b0;
    fq.delete();
    m_ov = 1'b0; m_ovf = 1'b0; m_od = 16'h0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK); #1;
    check_state();
    do_access(16'hFF02, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        push_word(16'($urandom));
      end else if (k == 2) begin
        do_ack();
      end else begin
        case ($urandom_range(0, 9))
          0:       ra = 16'hFF04;
          1:       ra = 16'hFEFF;
          2:       ra = 16'h1000 + 16'($urandom_range(0, 3));
          default: ra = 16'hFF00 + 16'($urandom_range(0, 3));
        endcase
        case ($urandom_range(0, 3))
          0, 1:    begin rr = 1'b1; rw = 1'b0; end
          2:       begin rr = 1'b0; rw = 1'b1; end
          default: begin rr = 1'b1; rw = 1'b1; end
        endcase
        rp = rr && !rw && (ra == 16'hFF00) && ($urandom_range(0, 3) == 0);
        do_access(ra, rr, rw, 16'($urandom), $urandom_range(0, 2), rp, 16'($urandom));
      end
    end

    repeat (4) @(posedge CLK);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
